// File: rtl/dd_pkg.sv
// Shared tile-luminance constants, width helpers and result types.
// Imported by the accumulator, its scan stage and the inversion-map writer.
package dd_pkg;

    localparam int LUM_W     = 10;
    localparam int LUM_MAX   = 765;
    localparam int RES_IDX_W = 8;
    localparam int RES_SUM_W = 32;
    localparam int RES_CNT_W = 16;

    typedef enum logic {IDLE, SCAN} scan_state_t;

    typedef struct packed {
        logic [RES_IDX_W-1:0] ht;
        logic [RES_IDX_W-1:0] vt;
        logic [RES_SUM_W-1:0] sum;
        logic [RES_CNT_W-1:0] cnt;
        logic                 dark;
    } tile_res_t;

    function automatic int sum_w(input int kh, input int kv);
        return $clog2(kh * kv * LUM_MAX + 1);
    endfunction

    function automatic int cnt_w(input int kh, input int kv);
        return $clog2(kh * kv + 1);
    endfunction

endpackage

// File: rtl/tile_scan.sv
// Snapshots a closed tile row and streams one result per tile with its dark flag.
// Latency: tile 0 one cycle after v_save, tile HBLKS-1 HBLKS cycles after (HBLKS >= 2).
// No backpressure: results are strobes; v_save mid-scan restarts and sets sticky overrun.
module tile_scan
    import dd_pkg::*;
#(
    parameter int  HBLKS  = 10,
    parameter int  VBLKS  = 10,
    parameter int  SW     = 20,
    parameter int  CW     = 10,
    parameter int  LUM_TH = 384,
    localparam int HW     = $clog2(HBLKS),
    localparam int VW     = $clog2(VBLKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic          v_save,
    input  logic [VW-1:0] vt_cur,
    input  logic [SW-1:0] col_sum [HBLKS],
    input  logic [CW-1:0] col_cnt [HBLKS],
    output logic          res_valid,
    output logic [HW-1:0] res_ht,
    output logic [VW-1:0] res_vt,
    output logic [SW-1:0] res_sum,
    output logic [CW-1:0] res_cnt,
    output logic          res_dark,
    output logic          overrun
);

    // LUM_TH <= LUM_MAX fits in LUM_W bits, so this width never truncates cnt*LUM_TH.
    localparam int PW = CW + LUM_W;

    scan_state_t   state, state_nxt;
    logic [HW-1:0] idx, idx_nxt;
    logic [SW-1:0] sh_sum [HBLKS];
    logic [CW-1:0] sh_cnt [HBLKS];
    logic [VW-1:0] vt_q;
    logic          emit;
    logic          start;
    logic [HW-1:0] src_ht;
    logic [VW-1:0] src_vt;
    logic [SW-1:0] src_sum;
    logic [CW-1:0] src_cnt;
    logic [PW-1:0] th_prod;
    logic          src_dark;

    assign start    = v_save && !vs;
    assign th_prod  = PW'(src_cnt) * PW'(LUM_TH);
    assign src_dark = PW'(src_sum) < th_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        emit      = 1'b0;
        src_ht    = idx;
        src_vt    = vt_q;
        src_sum   = sh_sum[idx];
        src_cnt   = sh_cnt[idx];
        if (vs) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else if (v_save) begin
            // Tile 0 is taken straight from the column buffer being snapshotted.
            emit      = 1'b1;
            src_ht    = '0;
            src_vt    = vt_cur;
            src_sum   = col_sum[0];
            src_cnt   = col_cnt[0];
            state_nxt = SCAN;
            idx_nxt   = HW'(1);
        end else if (state == SCAN) begin
            emit = 1'b1;
            if (idx == HW'(HBLKS - 1)) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_ht    <= '0;
            res_vt    <= '0;
            res_sum   <= '0;
            res_cnt   <= '0;
            res_dark  <= 1'b0;
            overrun   <= 1'b0;
            vt_q      <= '0;
            for (int k = 0; k < HBLKS; k++) begin
                sh_sum[k] <= '0;
                sh_cnt[k] <= '0;
            end
        end else begin
            res_valid <= emit;
            if (emit) begin
                res_ht   <= src_ht;
                res_vt   <= src_vt;
                res_sum  <= src_sum;
                res_cnt  <= src_cnt;
                res_dark <= src_dark;
            end
            if (start) begin
                sh_sum <= col_sum;
                sh_cnt <= col_cnt;
                vt_q   <= vt_cur;
                if (state == SCAN) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_luma_accum.sv
// Per-tile luminance accumulator: line accumulator plus per-column buffer, closed by v_save.
// Latency: first tile result 1 cycle after v_save, one result per cycle for HBLKS cycles.
// No backpressure: pixels are accepted every de cycle; results are unconditioned strobes.
module tile_luma_accum
    import dd_pkg::*;
#(
    parameter int  HBLKS  = 10,
    parameter int  VBLKS  = 10,
    parameter int  KH     = 30,
    parameter int  KV     = 30,
    parameter int  LUM_TH = 384,
    localparam int HW     = $clog2(HBLKS),
    localparam int VW     = $clog2(VBLKS),
    localparam int SW     = sum_w(KH, KV),
    localparam int CW     = cnt_w(KH, KV)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vs_i,
    input  logic          de_i,
    input  logic [23:0]   data_i,
    input  logic          h_save_i,
    input  logic          v_save_i,
    input  logic [HW-1:0] ht_cur_i,
    input  logic [VW-1:0] vt_cur_i,
    output logic          res_valid_o,
    output logic [HW-1:0] res_ht_o,
    output logic [VW-1:0] res_vt_o,
    output logic [SW-1:0] res_sum_o,
    output logic [CW-1:0] res_cnt_o,
    output logic          res_dark_o,
    output logic          overrun_o
);

    logic [LUM_W-1:0] lum;
    logic [SW-1:0]    acc_h;
    logic [CW-1:0]    cnt_h;
    logic [SW-1:0]    col_sum [HBLKS];
    logic [CW-1:0]    col_cnt [HBLKS];

    assign lum = LUM_W'(data_i[23:16]) + LUM_W'(data_i[15:8]) + LUM_W'(data_i[7:0]);

    always_ff @(posedge clk_i) begin
        if (rst_i || vs_i) begin
            acc_h <= '0;
            cnt_h <= '0;
            for (int k = 0; k < HBLKS; k++) begin
                col_sum[k] <= '0;
                col_cnt[k] <= '0;
            end
        end else begin
            if (de_i) begin
                if (h_save_i) begin
                    acc_h <= '0;
                    cnt_h <= '0;
                end else begin
                    acc_h <= acc_h + SW'(lum);
                    cnt_h <= cnt_h + CW'(1);
                end
            end
            // v_save comes with de low, so the row close never competes with a segment fold.
            if (v_save_i) begin
                for (int k = 0; k < HBLKS; k++) begin
                    col_sum[k] <= '0;
                    col_cnt[k] <= '0;
                end
            end else if (de_i && h_save_i) begin
                col_sum[ht_cur_i] <= col_sum[ht_cur_i] + acc_h + SW'(lum);
                col_cnt[ht_cur_i] <= col_cnt[ht_cur_i] + cnt_h + CW'(1);
            end
        end
    end

    tile_scan #(
        .HBLKS  (HBLKS),
        .VBLKS  (VBLKS),
        .SW     (SW),
        .CW     (CW),
        .LUM_TH (LUM_TH)
    ) u_scan (
        .clk       (clk_i),
        .rst       (rst_i),
        .vs        (vs_i),
        .v_save    (v_save_i),
        .vt_cur    (vt_cur_i),
        .col_sum   (col_sum),
        .col_cnt   (col_cnt),
        .res_valid (res_valid_o),
        .res_ht    (res_ht_o),
        .res_vt    (res_vt_o),
        .res_sum   (res_sum_o),
        .res_cnt   (res_cnt_o),
        .res_dark  (res_dark_o),
        .overrun   (overrun_o)
    );

endmodule

// File: tb/tb_tile_luma_accum.sv
// Bench for tile_luma_accum: a cursor emulator drives two instances (2 and 3 tiles per line),
// a per-tile model fills scoreboards, and a negedge monitor checks value and arrival cycle.
module tb_tile_luma_accum;

    localparam int LUM_TH = 384;
    localparam int KH     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vs, de, h_save, v_save, mode, vt;
    logic [23:0] data;
    logic [1:0]  ht;
    logic        de_a, hs_a, vsv_a, de_b, hs_b, vsv_b;

    assign de_a  = de && !mode;
    assign hs_a  = h_save && !mode;
    assign vsv_a = v_save && !mode;
    assign de_b  = de && mode;
    assign hs_b  = h_save && mode;
    assign vsv_b = v_save && mode;

    logic        res_valid_a, res_ht_a, res_vt_a, res_dark_a, overrun_a;
    logic [12:0] res_sum_a;
    logic [3:0]  res_cnt_a;
    logic        res_valid_b, res_vt_b, res_dark_b, overrun_b;
    logic [1:0]  res_ht_b;
    logic [12:0] res_sum_b;
    logic [3:0]  res_cnt_b;

    tile_luma_accum #(.HBLKS(2), .VBLKS(2), .KH(KH), .KV(2), .LUM_TH(LUM_TH)) dut_a (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .de_i(de_a), .data_i(data),
        .h_save_i(hs_a), .v_save_i(vsv_a), .ht_cur_i(ht[0]), .vt_cur_i(vt),
        .res_valid_o(res_valid_a), .res_ht_o(res_ht_a), .res_vt_o(res_vt_a),
        .res_sum_o(res_sum_a), .res_cnt_o(res_cnt_a), .res_dark_o(res_dark_a),
        .overrun_o(overrun_a)
    );

    tile_luma_accum #(.HBLKS(3), .VBLKS(2), .KH(KH), .KV(2), .LUM_TH(LUM_TH)) dut_b (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .de_i(de_b), .data_i(data),
        .h_save_i(hs_b), .v_save_i(vsv_b), .ht_cur_i(ht), .vt_cur_i(vt),
        .res_valid_o(res_valid_b), .res_ht_o(res_ht_b), .res_vt_o(res_vt_b),
        .res_sum_o(res_sum_b), .res_cnt_o(res_cnt_b), .res_dark_o(res_dark_b),
        .overrun_o(overrun_b)
    );

    typedef struct {
        int ht;
        int vt;
        int sum;
        int cnt;
        int dark;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   m_sum[3];
    int   m_cnt[3];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic take(input bit sel, input int vld, input int h, input int v,
                        input int s, input int c, input int d);
        exp_t  e;
        string p;
        p = sel ? "b" : "a";
        if ((sel && qb.size() == 0) || (!sel && qa.size() == 0)) begin
            chk_eq({p, "_spurious_valid"}, vld, 0);
            return;
        end
        if (sel) e = qb.pop_front();
        else     e = qa.pop_front();
        chk_eq({p, "_cycle"}, cyc, e.cyc);
        chk_eq({p, "_ht"},    h,   e.ht);
        chk_eq({p, "_vt"},    v,   e.vt);
        chk_eq({p, "_sum"},   s,   e.sum);
        chk_eq({p, "_cnt"},   c,   e.cnt);
        chk_eq({p, "_dark"},  d,   e.dark);
    endtask

    always @(negedge clk) begin
        if (res_valid_a)
            take(1'b0, int'(res_valid_a), int'(res_ht_a), int'(res_vt_a),
                 int'(res_sum_a), int'(res_cnt_a), int'(res_dark_a));
        if (res_valid_b)
            take(1'b1, int'(res_valid_b), int'(res_ht_b), int'(res_vt_b),
                 int'(res_sum_b), int'(res_cnt_b), int'(res_dark_b));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_model();
        for (int j = 0; j < 3; j++) begin
            m_sum[j] = 0;
            m_cnt[j] = 0;
        end
    endtask

    task automatic push_exp(input int j);
        exp_t e;
        e.ht   = j;
        e.vt   = int'(vt);
        e.sum  = m_sum[j];
        e.cnt  = m_cnt[j];
        e.dark = (m_sum[j] < m_cnt[j] * LUM_TH) ? 1 : 0;
        e.cyc  = cyc + 1 + j;
        if (mode) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic drive_line(input int hp, input logic [23:0] d0, input logic [23:0] d1,
                              input logic [23:0] d2);
        for (int x = 0; x < hp; x++) begin
            int t;
            t      = x / KH;
            de     = 1'b1;
            ht     = 2'(t);
            h_save = (x % KH == KH - 1) || (x == hp - 1);
            data   = (t == 0) ? d0 : (t == 1) ? d1 : d2;
            m_sum[t] += int'(data[23:16]) + int'(data[15:8]) + int'(data[7:0]);
            m_cnt[t] += 1;
            tick();
        end
        de     = 1'b0;
        h_save = 1'b0;
        data   = '0;
    endtask

    task automatic tile_row(input int hp, input logic [23:0] d0, input logic [23:0] d1,
                            input logic [23:0] d2);
        drive_line(hp, d0, d1, d2);
        idle(2);
        drive_line(hp, d0, d1, d2);
    endtask

    // v_save lands on the de falling edge; the cursor advances vt on that same edge.
    task automatic do_vsave(input int npush);
        v_save = 1'b1;
        for (int j = 0; j < npush; j++) push_exp(j);
        clear_model();
        tick();
        v_save = 1'b0;
        vt     = ~vt;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (qa.size() + qb.size()) != 0; i++) tick();
        chk_eq("drain_queue", qa.size() + qb.size(), 0);
        idle(2);
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; de = 1'b0; h_save = 1'b0; v_save = 1'b0;
        mode = 1'b0; data = '0; ht = '0; vt = 1'b0;
        clear_model();
        idle(3);
        chk_eq("rst_valid_a",   res_valid_a, 0);
        chk_eq("rst_ht_a",      res_ht_a,    0);
        chk_eq("rst_vt_a",      res_vt_a,    0);
        chk_eq("rst_sum_a",     res_sum_a,   0);
        chk_eq("rst_cnt_a",     res_cnt_a,   0);
        chk_eq("rst_dark_a",    res_dark_a,  0);
        chk_eq("rst_overrun_a", overrun_a,   0);
        chk_eq("rst_valid_b",   res_valid_b, 0);
        chk_eq("rst_overrun_b", overrun_b,   0);
        rst = 1'b0;
        idle(2);

        // uniform lum 240: sum 1920, cnt 8, dark
        tile_row(8, 24'h505050, 24'h505050, 24'h000000);
        do_vsave(2);
        wait_drain();

        // bright left tile, black right tile
        tile_row(8, 24'hFFFFFF, 24'h000000, 24'h000000);
        do_vsave(2);
        wait_drain();

        // second v_save one cycle into the scan
        tile_row(8, 24'h505050, 24'h505050, 24'h000000);
        do_vsave(1);
        do_vsave(2);
        chk_eq("overrun_set", overrun_a, 1);
        wait_drain();
        chk_eq("overrun_sticky", overrun_a, 1);

        // vs during a scan cuts it off; vs with v_save and a partial row leaves nothing behind
        tile_row(8, 24'h505050, 24'h505050, 24'h000000);
        do_vsave(1);
        vs = 1'b1;
        tick();
        vs = 1'b0;
        wait_drain();
        drive_line(8, 24'hFFFFFF, 24'hFFFFFF, 24'h000000);
        de = 1'b1; data = 24'hFFFFFF; ht = '0;
        idle(2);
        de = 1'b0; data = '0;
        vs = 1'b1; v_save = 1'b1;
        tick();
        vs = 1'b0; v_save = 1'b0; vt = 1'b0;
        clear_model();
        idle(2);
        tile_row(8, 24'h505050, 24'h505050, 24'h000000);
        do_vsave(2);
        wait_drain();
        chk_eq("overrun_survives_vs", overrun_a, 1);

        // reset mid-scan
        tile_row(8, 24'h505050, 24'h505050, 24'h000000);
        do_vsave(1);
        rst = 1'b1;
        tick();
        chk_eq("rst_mid_valid",   res_valid_a, 0);
        chk_eq("rst_mid_overrun", overrun_a,   0);
        chk_eq("rst_mid_sum",     res_sum_a,   0);
        rst = 1'b0;
        clear_model();
        idle(2);
        tile_row(8, 24'h101010, 24'hFF0000, 24'h000000);
        do_vsave(2);
        wait_drain();

        // three tiles, last one two pixels wide, lum 400
        mode = 1'b1;
        tile_row(10, 24'hC8C800, 24'hC8C800, 24'hC8C800);
        do_vsave(3);
        wait_drain();
        mode = 1'b0;
        chk_eq("overrun_b_clear", overrun_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tile_luma_accum.md
Name: tile_luma_accum

Overview:
- Downstream consumer of the tile cursor stage.
- Sums per-pixel luminance over each KH x KV tile, using the cursor's h_save/v_save strobes and tile indices.
- At the end of each tile row, emits one result per tile: sum, pixel count and a dark/bright decision.
- Results feed the per-tile inversion map written for the next frame.

Parameters:
- HBLKS, 10: tiles per line; must match the cursor stage.
- VBLKS, 10: tile rows per frame.
- KH, 30: nominal tile width in pixels.
- KV, 30: nominal tile height in lines.
- LUM_TH, 384: dark threshold on mean (R+G+B) per pixel, range 0..765.

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous active-high reset
- vs_i  in  1  vertical sync; clears accumulation state
- de_i  in  1  data enable
- data_i  in  24  pixel {R,G,B}, 8 bits each
- h_save_i  in  1  last pixel of a tile segment on this line
- v_save_i  in  1  last line of a tile row has completed
- ht_cur_i  in  $clog2(HBLKS)  current tile column
- vt_cur_i  in  $clog2(VBLKS)  current tile row
- res_valid_o  out  1  result strobe
- res_ht_o  out  $clog2(HBLKS)  tile column of the result
- res_vt_o  out  $clog2(VBLKS)  tile row of the result
- res_sum_o  out  SW  tile luminance sum; SW = $clog2(KH*KV*765+1)
- res_cnt_o  out  CW  tile pixel count; CW = $clog2(KH*KV+1)
- res_dark_o  out  1  high when res_sum_o < res_cnt_o*LUM_TH
- overrun_o  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators, column buffer and shadow buffer cleared.
- Pixel luminance: lum = R+G+B, zero-extended to 10 bits.
- Line accumulators:
  - acc_h (SW bits) and cnt_h (CW bits) update on de_i.
  - When de_i && ~h_save_i: acc_h += lum, cnt_h += 1.
  - When de_i && h_save_i: col_sum[ht_cur_i] += acc_h+lum, col_cnt[ht_cur_i] += cnt_h+1; acc_h and cnt_h clear to 0.
  - Column buffer: HBLKS-entry register array, so read-modify-write completes in one cycle.
- Tile row close, on v_save_i (which arrives on the de falling edge):
  - Copy col_sum/col_cnt into the shadow array.
  - Clear col_sum/col_cnt in the same cycle.
  - Latch vt_cur_i into vt_q. The cursor increments vt on this same edge, so the sampled value is the completed row.
  - Go to SCAN with index i=0.
- FSM:
  - IDLE -> SCAN on v_save_i.
  - SCAN emits one result per cycle. Each output is registered from shadow[i]; res_vt_o=vt_q, res_ht_o=i.
  - SCAN -> IDLE after i=HBLKS-1.
  - First result is valid 1 cycle after the v_save_i edge; the last is valid HBLKS cycles after it.
- Dark compare: cnt*LUM_TH is a constant multiply, computed at full width with no truncation.
- Edge tiles with width or height below KH/KV use their true count. cnt=0 gives dark=0 and sum=0.
- Boundary and error cases:
  - v_save_i during SCAN: set overrun_o, restart the scan from i=0 with the new snapshot; the remaining old results are dropped.
  - h_save_i during SCAN: legal. The column buffer and shadow buffer are independent.
  - vs_i: clears acc_h, cnt_h, col_*; FSM -> IDLE; res_valid_o=0 next cycle. overrun_o is not cleared (only rst_i clears it). vs_i has priority over v_save_i in the same cycle.
  - rst_i mid-SCAN: all state returns to reset values next cycle, with no further res_valid_o.
  - Arithmetic: accumulator widths are sized for the worst case (KH*KV*765), so no overflow for legal tiles. ht index wrap is not required; ht_cur_i < HBLKS is guaranteed.

Decomposition:
- Shared package dd_pkg holds:
  - luminance width constant (10)
  - max per-pixel luminance (765)
  - SW/CW derivation functions
  - tile result struct {ht, vt, sum, cnt, dark}, also consumed by the map writer.
- One natural sub-module, tile_scan: the shadow array, SCAN FSM and dark compare. tile_luma_accum owns the line accumulator and column buffer.

Test Plan (all cases HP=8, VP=4, KH=4, KV=2, HBLKS=2, VBLKS=2, LUM_TH=384):
- All pixels {80,80,80} (lum 240) for 2 lines, then v_save -> two results: ht=0,1; vt=0; sum=1920; cnt=8; dark=1. They arrive on consecutive cycles starting 1 cycle after v_save.
- Left tiles {FF,FF,FF}, right tiles {00,00,00} -> ht0: sum=6120, dark=0; ht1: sum=0, dark=1.
- HP=10 (edge tile 2 wide) with constant lum 400 -> ht2 result has cnt=4, sum=1600, dark=0. Use HBLKS=3 for this case.
- Second v_save injected 1 cycle into SCAN -> overrun_o=1 and stays 1. Results restart from ht=0 with the new snapshot.
- vs_i asserted mid-tile-row, then 2 clean lines -> the first results reflect only post-vs pixels (cnt=8).
- rst_i pulsed during SCAN -> res_valid_o=0 from the next cycle; overrun_o=0; the next tile row reports correct sums.
